// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, mode command characters and default line settings.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic [7:0] CMD_WATCH = 8'h21;
    localparam logic [7:0] CMD_SET   = 8'h40;
    localparam logic [7:0] CMD_ALARM = 8'h23;
    localparam logic [7:0] CMD_UART  = 8'h24;

    localparam int DEFAULT_CLK_FREQ = 50_000_000;
    localparam int DEFAULT_BAUD     = 115200;
    localparam int DEFAULT_OVS      = 16;

    // Clock cycles per oversample tick, truncated.
    function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
        return clk_freq / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_rx_cmd_if.sv
// Receiver-side bundle: serial line in, recovered byte and status strobes out.
interface uart_rx_cmd_if;
    logic       rxd;
    logic [7:0] data;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    modport master (input rxd, output data, output rx_done, output frame_err, output busy);
    modport slave  (output rxd, input data, input rx_done, input frame_err, input busy);
endinterface

// File: rtl/baud_tick_gen.sv
// Oversample tick divider shared by the UART receiver and transmitter.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUD     = DEFAULT_BAUD,
    parameter int OVS      = DEFAULT_OVS
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int DIV = calc_div(CLK_FREQ, BAUD, OVS);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // clr realigns the divider phase to the detected start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/uart_rx_cmd.sv
// 8N1 serial receiver with 16x oversampling; presents the last good byte for mode-command decoding.
module uart_rx_cmd
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
    parameter int BAUD     = DEFAULT_BAUD,
    parameter int OVS      = DEFAULT_OVS
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_cmd_if.master bus
);
    localparam int SCW = $clog2(OVS);
    localparam logic [SCW-1:0] SC_HALF = SCW'(OVS / 2 - 1);
    localparam logic [SCW-1:0] SC_LAST = SCW'(OVS - 1);

    rx_state_t      state;
    logic [1:0]     sync_q;
    logic           rxd_s;
    logic           tick;
    logic           clr;
    logic [SCW-1:0] sc;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic [7:0]     data_q;
    logic           rx_done_q;
    logic           frame_err_q;
    logic           busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.rxd};
        end
    end

    assign rxd_s = sync_q[1];
    assign clr   = (state == IDLE) && !rxd_s;

    baud_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .OVS      (OVS)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    // START samples half a bit in; later samples fall a full bit apart, i.e. mid-bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sc          <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            data_q      <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state  <= START;
                        sc     <= '0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (sc == SC_HALF) begin
                            sc <= '0;
                            if (!rxd_s) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end else begin
                                state  <= IDLE;
                                busy_q <= 1'b0;
                            end
                        end else begin
                            sc <= sc + SCW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (sc == SC_LAST) begin
                            sc    <= '0;
                            shreg <= {rxd_s, shreg[7:1]};
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end else begin
                            sc <= sc + SCW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (sc == SC_LAST) begin
                            sc <= '0;
                            if (rxd_s) begin
                                data_q    <= shreg;
                                rx_done_q <= 1'b1;
                                busy_q    <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state       <= BREAK;
                            end
                        end else begin
                            sc <= sc + SCW'(1);
                        end
                    end
                end
                BREAK: begin
                    // A held-low line must return high before another start is accepted.
                    if (rxd_s) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.rx_done   = rx_done_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Directed bench for uart_rx_cmd at 50 MHz / 115200 baud (432 clk per bit).
module tb_uart_rx_cmd;

    localparam int BIT_CLK = 432;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_cmd_if bus ();

    uart_rx_cmd #(
        .CLK_FREQ (50_000_000),
        .BAUD     (115200),
        .OVS      (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int cycle = 0;
    int done_count = 0;
    int err_count = 0;
    int last_done_cycle = 0;
    int prev_done_cycle = 0;
    int pulse_violations = 0;
    int start_cycle = 0;
    logic prev_done = 1'b0;
    logic prev_err = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    // Pulse monitor: counts strobes and flags overlapping or stretched pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_done) begin
                done_count++;
                prev_done_cycle = last_done_cycle;
                last_done_cycle = cycle;
            end
            if (bus.frame_err) err_count++;
            if ((bus.rx_done && bus.frame_err) || (bus.rx_done && prev_done) ||
                (bus.frame_err && prev_err))
                pulse_violations++;
            prev_done = bus.rx_done;
            prev_err  = bus.frame_err;
        end else begin
            prev_done = 1'b0;
            prev_err  = 1'b0;
        end
    end

    initial begin
        #(20 * 90000);
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic driveBit(input logic value, input int period);
        bus.rxd = value;
        waitClk(period);
    endtask

    task automatic applyStimulus(input logic [7:0] value, input int period, input logic stop_bit);
        start_cycle = cycle;
        driveBit(1'b0, period);
        for (int i = 0; i < 8; i++) driveBit(value[i], period);
        driveBit(stop_bit, period);
    endtask

    int d0;
    int e0;
    int latency;
    int gap;

    initial begin
        bus.rxd = 1'b1;
        rst = 1'b1;
        waitClk(5);
        checkOutput("reset_data", {24'h0, bus.data}, 32'h00);
        checkOutput("reset_rx_done", {31'h0, bus.rx_done}, 32'h0);
        checkOutput("reset_frame_err", {31'h0, bus.frame_err}, 32'h0);
        checkOutput("reset_busy", {31'h0, bus.busy}, 32'h0);
        rst = 1'b0;
        waitClk(50);

        // Clean 0x21 frame
        d0 = done_count; e0 = err_count;
        applyStimulus(8'h21, BIT_CLK, 1'b1);
        waitClk(20);
        latency = last_done_cycle - start_cycle;
        checkOutput("frame21_data", {24'h0, bus.data}, 32'h21);
        checkOutput("frame21_done_count", done_count - d0, 1);
        checkOutput("frame21_err_count", err_count - e0, 0);
        checkOutput("frame21_latency", (latency >= 4100 && latency <= 4115) ? 1 : 0, 1);
        checkOutput("frame21_busy_idle", {31'h0, bus.busy}, 32'h0);

        // 100 clk glitch on an idle line
        d0 = done_count; e0 = err_count;
        driveBit(1'b0, 100);
        bus.rxd = 1'b1;
        checkOutput("glitch_busy_during", {31'h0, bus.busy}, 32'h1);
        waitClk(200);
        checkOutput("glitch_busy_after", {31'h0, bus.busy}, 32'h0);
        checkOutput("glitch_no_done", done_count - d0, 0);
        checkOutput("glitch_no_err", err_count - e0, 0);
        checkOutput("glitch_data_kept", {24'h0, bus.data}, 32'h21);
        waitClk(500);

        // Back-to-back 0x40, 0x23 with minimal stop bit
        d0 = done_count;
        applyStimulus(8'h40, BIT_CLK, 1'b1);
        applyStimulus(8'h23, BIT_CLK, 1'b1);
        waitClk(20);
        gap = last_done_cycle - prev_done_cycle;
        checkOutput("b2b_done_count", done_count - d0, 2);
        checkOutput("b2b_gap", (gap >= 4310 && gap <= 4330) ? 1 : 0, 1);
        checkOutput("b2b_data", {24'h0, bus.data}, 32'h23);
        waitClk(200);

        // 0x24 with bad stop bit, then line held low
        d0 = done_count; e0 = err_count;
        applyStimulus(8'h24, BIT_CLK, 1'b0);
        waitClk(5000);
        checkOutput("ferr_err_count", err_count - e0, 1);
        checkOutput("ferr_no_done", done_count - d0, 0);
        checkOutput("ferr_data_kept", {24'h0, bus.data}, 32'h23);
        checkOutput("ferr_busy_while_low", {31'h0, bus.busy}, 32'h1);
        bus.rxd = 1'b1;
        waitClk(10);
        checkOutput("ferr_busy_released", {31'h0, bus.busy}, 32'h0);
        waitClk(200);

        // Reset during bit 4 of 0x55
        d0 = done_count; e0 = err_count;
        driveBit(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) driveBit(((8'h55 >> i) & 8'h01) != 0, BIT_CLK);
        driveBit(1'b1, 200);
        rst = 1'b1;
        #1;
        checkOutput("midreset_data", {24'h0, bus.data}, 32'h00);
        checkOutput("midreset_busy", {31'h0, bus.busy}, 32'h0);
        waitClk(5);
        rst = 1'b0;
        waitClk(1000);
        checkOutput("midreset_no_pulse", (done_count - d0) + (err_count - e0), 0);
        d0 = done_count;
        applyStimulus(8'hAA, BIT_CLK, 1'b1);
        waitClk(20);
        checkOutput("post_reset_data", {24'h0, bus.data}, 32'hAA);
        checkOutput("post_reset_done", done_count - d0, 1);
        waitClk(200);

        // Baud tolerance: +3% and -3% bit periods
        d0 = done_count;
        applyStimulus(8'h21, 445, 1'b1);
        waitClk(20);
        checkOutput("slow_baud_data", {24'h0, bus.data}, 32'h21);
        checkOutput("slow_baud_done", done_count - d0, 1);
        applyStimulus(8'h5A, BIT_CLK, 1'b1);
        waitClk(20);
        checkOutput("interposed_data", {24'h0, bus.data}, 32'h5A);
        d0 = done_count;
        applyStimulus(8'h21, 419, 1'b1);
        waitClk(20);
        checkOutput("fast_baud_data", {24'h0, bus.data}, 32'h21);
        checkOutput("fast_baud_done", done_count - d0, 1);

        checkOutput("pulse_shape", pulse_violations, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
